// File: rtl/pulse_peak_finder.sv
// pulse_peak_finder: threshold/hysteresis pulse detector reporting
// peak amplitude, time of peak and pulse width for one filter channel.
module pulse_peak_finder #(
  parameter int DATA_W    = 16,
  parameter int TS_W      = 32,
  parameter int WID_W     = 8,
  parameter int MAX_WIDTH = 200,
  parameter int HYST      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic signed [DATA_W-1:0] input_data,
  output logic                     peak_valid,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic        [TS_W-1:0]   peak_time,
  output logic        [WID_W-1:0]  peak_width,
  output logic                     peak_timeout,
  output logic        [15:0]       event_count
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLDOFF
  } state_t;

  localparam logic [WID_W-1:0] W_MAX = WID_W'(MAX_WIDTH);
  localparam logic signed [DATA_W:0] HYST_EXT = (DATA_W+1)'(HYST);
  localparam logic signed [DATA_W:0] MIN_EXT =
    {2'b11, {(DATA_W-1){1'b0}}};

  state_t state, state_n;

  logic        [TS_W-1:0]   ts;
  logic signed [DATA_W-1:0] max_r, max_n;
  logic        [TS_W-1:0]   tmax_r, tmax_n;
  logic        [WID_W-1:0]  width_r, width_n;
  logic                     report;
  logic                     timeout;

  logic signed [DATA_W:0]   exit_ext;
  logic signed [DATA_W-1:0] exit_lvl;
  logic                     trig;
  logic                     above;
  logic                     new_max;

  // One extra bit so a very negative threshold cannot wrap positive.
  assign exit_ext = {threshold[DATA_W-1], threshold} - HYST_EXT;
  assign exit_lvl = (exit_ext < MIN_EXT) ? MIN_EXT[DATA_W-1:0]
                                         : exit_ext[DATA_W-1:0];

  assign trig    = input_data > threshold;
  assign above   = input_data > exit_lvl;
  assign new_max = input_data > max_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    max_n   = max_r;
    tmax_n  = tmax_r;
    width_n = width_r;
    report  = 1'b0;
    timeout = 1'b0;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (trig) begin
            max_n   = input_data;
            tmax_n  = ts;
            width_n = WID_W'(1);
            state_n = TRACK;
            if (width_n == W_MAX) begin
              report  = 1'b1;
              timeout = 1'b1;
              state_n = HOLDOFF;
            end
          end
        end
        TRACK: begin
          if (above) begin
            width_n = width_r + 1'b1;
            if (new_max) begin
              max_n  = input_data;
              tmax_n = ts;
            end
            if (width_n == W_MAX) begin
              report  = 1'b1;
              timeout = 1'b1;
              state_n = HOLDOFF;
            end
          end else begin
            report  = 1'b1;
            state_n = IDLE;
          end
        end
        HOLDOFF: begin
          if (!above) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Report fields are latched on the deciding edge and held until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts           <= '0;
      max_r        <= '0;
      tmax_r       <= '0;
      width_r      <= '0;
      peak_valid   <= 1'b0;
      peak_amp     <= '0;
      peak_time    <= '0;
      peak_width   <= '0;
      peak_timeout <= 1'b0;
      event_count  <= '0;
    end else begin
      ts         <= ts + 1'b1;
      max_r      <= max_n;
      tmax_r     <= tmax_n;
      width_r    <= width_n;
      peak_valid <= report;
      if (report) begin
        peak_amp     <= max_n;
        peak_time    <= tmax_n;
        peak_width   <= width_n;
        peak_timeout <= timeout;
        event_count  <= event_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_peak_finder.sv
// tb_pulse_peak_finder: scoreboard bench for pulse_peak_finder
// with default parameters (thr/hyst/timeout scenarios).
module tb_pulse_peak_finder;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b1;
  logic signed [15:0] threshold = 16'sd100;
  logic signed [15:0] input_data = 16'sd0;
  logic               peak_valid;
  logic signed [15:0] peak_amp;
  logic        [31:0] peak_time;
  logic        [7:0]  peak_width;
  logic               peak_timeout;
  logic        [15:0] event_count;

  typedef struct {
    logic signed [15:0] amp;
    logic [31:0]        tm;
    logic [7:0]         wid;
    logic               to;
    logic [15:0]        cnt;
    int                 due;
  } rec_t;

  rec_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          edge_n = 0;
  logic [15:0] exp_count = 16'd0;

  pulse_peak_finder dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .threshold    (threshold),
    .input_data   (input_data),
    .peak_valid   (peak_valid),
    .peak_amp     (peak_amp),
    .peak_time    (peak_time),
    .peak_width   (peak_width),
    .peak_timeout (peak_timeout),
    .event_count  (event_count)
  );

  always #5 clk = ~clk;

  // Edges since reset release; equals the time stamp of the next sample.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else edge_n <= edge_n + 1;
  end

  task automatic drive(input logic signed [15:0] v);
    @(negedge clk);
    input_data = v;
  endtask

  task automatic send(input logic signed [15:0] v, output int t);
    drive(v);
    t = edge_n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'sd0);
  endtask

  task automatic push_exp(input logic signed [15:0] a, input int tm,
                          input int w, input logic to, input int due);
    rec_t r;
    exp_count = exp_count + 16'd1;
    r.amp = a;
    r.tm  = tm;
    r.wid = 8'(w);
    r.to  = to;
    r.cnt = exp_count;
    r.due = due;
    sb.push_back(r);
  endtask

  task automatic monitor();
    rec_t r;
    forever begin
      @(negedge clk);
      if (!reset && peak_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL strobe_unexpected: got amp=%0d width=%0d at edge %0d, required no strobe",
                   peak_amp, peak_width, edge_n);
        end else begin
          r = sb.pop_front();
          total++;
          if (edge_n != r.due) begin
            bad++;
            $display("FAIL strobe_latency: got edge %0d, required %0d", edge_n, r.due);
          end
          total++;
          if (peak_amp !== r.amp) begin
            bad++;
            $display("FAIL peak_amp: got %0d, required %0d", peak_amp, r.amp);
          end
          total++;
          if (peak_time !== r.tm) begin
            bad++;
            $display("FAIL peak_time: got %0d, required %0d", peak_time, r.tm);
          end
          total++;
          if (peak_width !== r.wid) begin
            bad++;
            $display("FAIL peak_width: got %0d, required %0d", peak_width, r.wid);
          end
          total++;
          if (peak_timeout !== r.to) begin
            bad++;
            $display("FAIL peak_timeout: got %0b, required %0b", peak_timeout, r.to);
          end
          total++;
          if (event_count !== r.cnt) begin
            bad++;
            $display("FAIL event_count: got %0d, required %0d", event_count, r.cnt);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    threshold = 16'sd100;
    input_data = 16'sd0;
    repeat (3) @(negedge clk);
    total++;
    if (peak_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %0b, required 0", peak_valid);
    end
    total++;
    if (peak_amp !== 16'sd0) begin
      bad++; $display("FAIL reset_amp: got %0d, required 0", peak_amp);
    end
    total++;
    if (peak_time !== 32'd0) begin
      bad++; $display("FAIL reset_time: got %0d, required 0", peak_time);
    end
    total++;
    if (peak_width !== 8'd0) begin
      bad++; $display("FAIL reset_width: got %0d, required 0", peak_width);
    end
    total++;
    if (peak_timeout !== 1'b0) begin
      bad++; $display("FAIL reset_timeout: got %0b, required 0", peak_timeout);
    end
    total++;
    if (event_count !== 16'd0) begin
      bad++; $display("FAIL reset_count: got %0d, required 0", event_count);
    end
    exp_count = 16'd0;
    reset = 1'b0;
  endtask

  task automatic end_checks(input string name);
    idle(4);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_missing: got %0d strobes outstanding, required 0", name, sb.size());
      sb.delete();
    end
    total++;
    if (event_count !== exp_count) begin
      bad++;
      $display("FAIL %s_count: got %0d, required %0d", name, event_count, exp_count);
    end
  endtask

  task automatic test_basic();
    int t, t300, t96;
    drive(16'sd0);
    drive(16'sd0);
    drive(16'sd150);
    send(16'sd300, t300);
    drive(16'sd250);
    drive(16'sd120);
    send(16'sd96, t96);
    push_exp(16'sd300, t300, 4, 1'b0, t96 + 1);
    send(16'sd0, t);
    end_checks("basic");
    total++;
    if (peak_amp !== 16'sd300 || peak_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold: got amp=%0d valid=%0b, required amp=300 valid=0",
               peak_amp, peak_valid);
    end
  endtask

  task automatic test_plateau();
    int t1, t4;
    drive(16'sd0);
    send(16'sd200, t1);
    drive(16'sd200);
    drive(16'sd200);
    send(16'sd0, t4);
    push_exp(16'sd200, t1, 3, 1'b0, t4 + 1);
    end_checks("plateau");
  endtask

  task automatic test_timeout();
    int t, tfirst, t1, t2;
    tfirst = 0;
    for (int i = 0; i < 300; i++) begin
      send(16'sd500, t);
      if (i == 0) tfirst = t;
      if (i == 199) push_exp(16'sd500, tfirst, 200, 1'b1, t + 1);
    end
    drive(16'sd0);
    send(16'sd150, t1);
    send(16'sd0, t2);
    push_exp(16'sd150, t1, 1, 1'b0, t2 + 1);
    end_checks("timeout");
  endtask

  task automatic test_back_to_back();
    int ta, tb, tc, td;
    drive(16'sd0);
    send(16'sd150, ta);
    send(16'sd0, tb);
    push_exp(16'sd150, ta, 1, 1'b0, tb + 1);
    send(16'sd160, tc);
    send(16'sd0, td);
    push_exp(16'sd160, tc, 1, 1'b0, td + 1);
    end_checks("b2b");
  endtask

  task automatic test_negative();
    int t, t2, t3, tmx;
    logic signed [15:0] v;
    @(negedge clk);
    input_data = -16'sd100;
    threshold = -16'sd50;
    drive(-16'sd100);
    drive(-16'sd20);
    send(-16'sd10, t2);
    send(-16'sd60, t3);
    push_exp(-16'sd10, t2, 2, 1'b0, t3 + 1);
    drive(-16'sd100);
    drive(-16'sd100);
    @(negedge clk);
    input_data = 16'sh8000;
    threshold = 16'sh8000;
    drive(16'sh8000);
    tmx = 0;
    for (int i = 0; i < 200; i++) begin
      v = (i % 2 == 0) ? 16'sh8001 : -16'sd32000;
      send(v, t);
      if (i == 1) tmx = t;
      if (i == 199) push_exp(-16'sd32000, tmx, 200, 1'b1, t + 1);
    end
    drive(16'sh8000);
    drive(16'sh8000);
    threshold = 16'sd100;
    end_checks("negative");
  endtask

  task automatic test_abort();
    int t1, t2;
    threshold = 16'sd100;
    drive(16'sd0);
    drive(16'sd150);
    drive(16'sd200);
    #2 reset = 1'b1;
    #1;
    total++;
    if (peak_valid !== 1'b0 || peak_amp !== 16'sd0 || peak_time !== 32'd0) begin
      bad++;
      $display("FAIL async_reset_fields: got valid=%0b amp=%0d time=%0d, required 0 0 0",
               peak_valid, peak_amp, peak_time);
    end
    total++;
    if (event_count !== 16'd0 || peak_width !== 8'd0) begin
      bad++;
      $display("FAIL async_reset_count: got count=%0d width=%0d, required 0 0",
               event_count, peak_width);
    end
    sb.delete();
    exp_count = 16'd0;
    input_data = 16'sd0;
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    drive(16'sd150);
    drive(16'sd250);
    enable = 1'b0;
    drive(16'sd0);
    enable = 1'b1;
    drive(16'sd0);
    total++;
    if (event_count !== 16'd0) begin
      bad++;
      $display("FAIL enable_abort_count: got %0d, required 0", event_count);
    end
    send(16'sd180, t1);
    send(16'sd0, t2);
    push_exp(16'sd180, t1, 1, 1'b0, t2 + 1);
    end_checks("abort");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_plateau();
    test_timeout();
    test_back_to_back();
    test_negative();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
